pim_exec_scheduler: RTL and testbench

Shares the eFlash PIM datapath (row driver, column driver, output buffer) between two command requesters: port 0 is the RISC-V MMIO path and port 1 is the DMA/host path. It arbitrates between the two round-robin and latches the winning command (mode, row, column). It then sequences the execution phase by driving pim_en, pim_mode, exec_cnt, row_addr7 and col_addr9, and reports completion or error to the granted requester.

---
 rtl/peri_pkg.sv | 45 ++++
 rtl/pim_rr_arbiter.sv | 27 ++
 rtl/pim_exec_scheduler.sv | 134 +++++++++++++
 tb/tb_pim_exec_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peri_pkg.sv
// Shared types and helpers for the PIM execution scheduler.
// Holds the mode/state enums and the mode-to-length mapping.
package peri_pkg;

  localparam int EXEC_LEN_W = 4;

  typedef enum logic [2:0] {
    MODE_READ  = 3'd1,
    MODE_PROG  = 3'd2,
    MODE_ERASE = 3'd3,
    MODE_COMP  = 3'd4,
    MODE_LOAD  = 3'd5
  } pim_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_DONE  = 3'd2,
    ST_ABORT = 3'd3,
    ST_ERR   = 3'd4
  } sched_state_e;

  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode >= 3'd1) && (mode <= 3'd5);
  endfunction

  // Returns the final exec_cnt index (LEN-1) so it fits the 4-bit counter.
  function automatic logic [EXEC_LEN_W-1:0] exec_last(
    input logic [2:0] mode,
    input int len_read, input int len_prog, input int len_erase,
    input int len_comp, input int len_load
  );
    int len;
    case (mode)
      MODE_READ:  len = len_read;
      MODE_PROG:  len = len_prog;
      MODE_ERASE: len = len_erase;
      MODE_COMP:  len = len_comp;
      MODE_LOAD:  len = len_load;
      default:    len = 1;
    endcase
    return EXEC_LEN_W'(len - 1);
  endfunction

endpackage

// File: rtl/pim_rr_arbiter.sv
// Two-way round-robin arbiter; rr_ptr names the requester favoured on a tie
// and flips to the loser after every grant.
module pim_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_valid_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic rr_ptr;

  always_comb begin
    gnt_valid_o = enable_i & (|req_valid_i);
    gnt_idx_o   = (req_valid_i == 2'b11) ? rr_ptr : req_valid_i[1];
    grant_o     = 2'b00;
    if (gnt_valid_o) grant_o = gnt_idx_o ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr <= 1'b0;
    else if (gnt_valid_o) rr_ptr <= ~gnt_idx_o;
  end

endmodule

// File: rtl/pim_exec_scheduler.sv
// Arbitrates two requesters onto the eFlash PIM datapath and sequences execution.
// Optional per-requester success counters: define PIM_SCHED_STATS_EN.
module pim_exec_scheduler
  import peri_pkg::*;
#(
  parameter int LEN_READ  = 8,
  parameter int LEN_PROG  = 12,
  parameter int LEN_ERASE = 14,
  parameter int LEN_COMP  = 10,
  parameter int LEN_LOAD  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_valid_i,
  output logic [1:0] req_ready_o,
  input  logic [2:0] req0_mode_i,
  input  logic [2:0] req1_mode_i,
  input  logic [6:0] req0_row_i,
  input  logic [6:0] req1_row_i,
  input  logic [8:0] req0_col_i,
  input  logic [8:0] req1_col_i,
  input  logic       abort_i,
  output logic       pim_en_o,
  output logic [2:0] pim_mode_o,
  output logic [3:0] exec_cnt_o,
  output logic [6:0] row_addr7_o,
  output logic [8:0] col_addr9_o,
  output logic       busy_o,
  output logic [1:0] done_o,
  output logic       err_o
`ifdef PIM_SCHED_STATS_EN
  ,
  output logic [15:0] stat_ops0_o,
  output logic [15:0] stat_ops1_o
`endif
);

  sched_state_e state_q, state_d;
  logic [2:0] mode_q;
  logic [6:0] row_q;
  logic [8:0] col_q;
  logic       gnt_q;
  logic [EXEC_LEN_W-1:0] cnt_q;
  logic [EXEC_LEN_W-1:0] last_idx;
  logic       gnt_valid, gnt_idx;
  logic [2:0] sel_mode;
  logic       finishing;

  pim_rr_arbiter u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .enable_i    (state_q == ST_IDLE),
    .grant_o     (req_ready_o),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign sel_mode = gnt_idx ? req1_mode_i : req0_mode_i;
  assign last_idx = exec_last(mode_q, LEN_READ, LEN_PROG, LEN_ERASE, LEN_COMP, LEN_LOAD);

  // Abort is only honoured before the final exec cycle.
  always_comb begin
    state_d   = state_q;
    pim_en_o  = 1'b0;
    finishing = 1'b0;
    err_o     = 1'b0;
    case (state_q)
      ST_IDLE: if (gnt_valid) state_d = mode_legal(sel_mode) ? ST_EXEC : ST_ERR;
      ST_EXEC: begin
        pim_en_o = 1'b1;
        if (cnt_q == last_idx) state_d = ST_DONE;
        else if (abort_i) state_d = ST_ABORT;
      end
      ST_DONE: begin
        finishing = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_ABORT, ST_ERR: begin
        finishing = 1'b1;
        err_o     = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_valid) begin
        gnt_q  <= gnt_idx;
        mode_q <= sel_mode;
        row_q  <= gnt_idx ? req1_row_i : req0_row_i;
        col_q  <= gnt_idx ? req1_col_i : req0_col_i;
      end
      if (state_q == ST_EXEC && state_d == ST_EXEC) cnt_q <= cnt_q + 1'b1;
      else cnt_q <= '0;
    end
  end

  assign done_o      = finishing ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o      = (state_q != ST_IDLE);
  assign exec_cnt_o  = cnt_q;
  assign pim_mode_o  = mode_q;
  assign row_addr7_o = row_q;
  assign col_addr9_o = col_q;

`ifdef PIM_SCHED_STATS_EN
  logic [15:0] ops0_q, ops1_q;

  // Only clean completions count; counters stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ops0_q <= '0;
      ops1_q <= '0;
    end else if (state_q == ST_DONE) begin
      if (!gnt_q && ops0_q != 16'hFFFF) ops0_q <= ops0_q + 16'd1;
      if (gnt_q && ops1_q != 16'hFFFF) ops1_q <= ops1_q + 16'd1;
    end
  end

  assign stat_ops0_o = ops0_q;
  assign stat_ops1_o = ops1_q;
`endif

endmodule

// File: tb/tb_pim_exec_scheduler.sv
// Self-checking bench for pim_exec_scheduler: transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pim_exec_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] req_valid_i = '0;
  logic [1:0] req_ready_o;
  logic [2:0] req0_mode_i = '0, req1_mode_i = '0;
  logic [6:0] req0_row_i = '0, req1_row_i = '0;
  logic [8:0] req0_col_i = '0, req1_col_i = '0;
  logic       abort_i = 1'b0;
  logic       pim_en_o;
  logic [2:0] pim_mode_o;
  logic [3:0] exec_cnt_o;
  logic [6:0] row_addr7_o;
  logic [8:0] col_addr9_o;
  logic       busy_o;
  logic [1:0] done_o;
  logic       err_o;
`ifdef PIM_SCHED_STATS_EN
  logic [15:0] stat_ops0_o, stat_ops1_o;
`endif

  int n_checks = 0;
  int n_fail = 0;

  pim_exec_scheduler dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req0_mode_i (req0_mode_i),
    .req1_mode_i (req1_mode_i),
    .req0_row_i  (req0_row_i),
    .req1_row_i  (req1_row_i),
    .req0_col_i  (req0_col_i),
    .req1_col_i  (req1_col_i),
    .abort_i     (abort_i),
    .pim_en_o    (pim_en_o),
    .pim_mode_o  (pim_mode_o),
    .exec_cnt_o  (exec_cnt_o),
    .row_addr7_o (row_addr7_o),
    .col_addr9_o (col_addr9_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
`ifdef PIM_SCHED_STATS_EN
    ,
    .stat_ops0_o (stat_ops0_o),
    .stat_ops1_o (stat_ops1_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [2:0] m0, input logic [6:0] r0, input logic [8:0] c0,
                               input logic [2:0] m1, input logic [6:0] r1, input logic [8:0] c1,
                               input logic ab);
    @(posedge clk_i);
    #1;
    req_valid_i = v;
    req0_mode_i = m0; req0_row_i = r0; req0_col_i = c0;
    req1_mode_i = m1; req1_row_i = r1; req1_col_i = c1;
    abort_i = ab;
  endtask

  // Steps posedges until the given exec index is showing; returns just after the edge.
  task automatic waitCnt(input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i);
      #1;
      if (pim_en_o && int'(exec_cnt_o) == target) begin
        ok = 1'b1;
        return;
      end
    end
    checkOutput("wait_exec_cnt_timeout", 0, 1);
  endtask

  function automatic int lenOf(input logic [2:0] m);
    case (m)
      3'd1: return 8;
      3'd2: return 12;
      3'd3: return 14;
      3'd4: return 10;
      3'd5: return 4;
      default: return 0;
    endcase
  endfunction

  // Reference model: one outstanding command described by its age in cycles.
  bit         m_busy, m_gnt, m_illegal, m_aborted, m_rr;
  int         m_t, m_len, m_end;
  logic [2:0] m_mode;
  logic [6:0] m_row;
  logic [8:0] m_col;
  int         m_ops0, m_ops1;

  always @(negedge clk_i) begin
    int e_ready, e_en, e_cnt, e_done, e_err;
    int g;
    if (!rst_ni) begin
      m_busy = 0; m_gnt = 0; m_illegal = 0; m_aborted = 0; m_rr = 0;
      m_t = 0; m_len = 0; m_end = 0;
      m_mode = '0; m_row = '0; m_col = '0;
      m_ops0 = 0; m_ops1 = 0;
      checkOutput("rst_ready", int'(req_ready_o), 0);
      checkOutput("rst_pim_en", int'(pim_en_o), 0);
      checkOutput("rst_busy", int'(busy_o), 0);
      checkOutput("rst_done", int'(done_o), 0);
      checkOutput("rst_err", int'(err_o), 0);
      checkOutput("rst_cnt", int'(exec_cnt_o), 0);
      checkOutput("rst_row", int'(row_addr7_o), 0);
      checkOutput("rst_col", int'(col_addr9_o), 0);
      checkOutput("rst_mode", int'(pim_mode_o), 0);
    end else begin
      e_ready = 0; e_en = 0; e_cnt = 0; e_done = 0; e_err = 0; g = 0;
      if (!m_busy) begin
        if (req_valid_i != 2'b00) begin
          g = (req_valid_i == 2'b11) ? int'(m_rr) : int'(req_valid_i[1]);
          e_ready = 1 << g;
        end
      end else if (m_illegal) begin
        e_done = 1 << m_gnt;
        e_err = 1;
      end else if (m_t < m_end) begin
        e_en = 1;
        e_cnt = m_t - 1;
      end else begin
        e_done = 1 << m_gnt;
        e_err = int'(m_aborted);
      end
      checkOutput("ready", int'(req_ready_o), e_ready);
      checkOutput("pim_en", int'(pim_en_o), e_en);
      checkOutput("exec_cnt", int'(exec_cnt_o), e_cnt);
      checkOutput("done", int'(done_o), e_done);
      checkOutput("err", int'(err_o), e_err);
      checkOutput("busy", int'(busy_o), int'(m_busy));
      checkOutput("mode", int'(pim_mode_o), int'(m_mode));
      checkOutput("row", int'(row_addr7_o), int'(m_row));
      checkOutput("col", int'(col_addr9_o), int'(m_col));
`ifdef PIM_SCHED_STATS_EN
      checkOutput("stat0", int'(stat_ops0_o), m_ops0);
      checkOutput("stat1", int'(stat_ops1_o), m_ops1);
`endif
      if (!m_busy) begin
        if (req_valid_i != 2'b00) begin
          m_gnt = (g == 1);
          m_rr = ~m_gnt;
          m_mode = m_gnt ? req1_mode_i : req0_mode_i;
          m_row = m_gnt ? req1_row_i : req0_row_i;
          m_col = m_gnt ? req1_col_i : req0_col_i;
          m_len = lenOf(m_mode);
          m_illegal = (m_len == 0);
          m_end = m_len + 1;
          m_aborted = 0;
          m_t = 1;
          m_busy = 1;
        end
      end else if (m_illegal || m_t == m_end) begin
        if (!m_illegal && !m_aborted) begin
          if (!m_gnt && m_ops0 < 65535) m_ops0++;
          if (m_gnt && m_ops1 < 65535) m_ops1++;
        end
        m_busy = 0;
      end else begin
        if (abort_i && m_t < m_len) begin
          m_end = m_t + 1;
          m_aborted = 1;
        end
        m_t++;
      end
    end
  end

  initial begin
    bit ok;
    int n_gr;
    logic [1:0] grants[8];

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Lone READ from requester 0.
    applyStimulus(2'b01, 3'd1, 7'd5, 9'd17, 3'd0, 7'd0, 9'd0, 1'b0);
    @(negedge clk_i);
    checkOutput("read_ready0", int'(req_ready_o), 1);
    applyStimulus(2'b00, 3'd1, 7'd5, 9'd17, 3'd0, 7'd0, 9'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      checkOutput("read_en", int'(pim_en_o), 1);
      checkOutput("read_cnt", int'(exec_cnt_o), i);
      checkOutput("read_row", int'(row_addr7_o), 5);
      checkOutput("read_col", int'(col_addr9_o), 17);
    end
    @(negedge clk_i);
    checkOutput("read_done", int'(done_o), 1);
    checkOutput("read_err", int'(err_o), 0);
    checkOutput("read_en_off", int'(pim_en_o), 0);

    // Illegal mode on requester 1.
    applyStimulus(2'b10, 3'd0, 7'd0, 9'd0, 3'd7, 7'd3, 9'd4, 1'b0);
    @(negedge clk_i);
    checkOutput("illegal_ready1", int'(req_ready_o), 2);
    applyStimulus(2'b00, 3'd0, 7'd0, 9'd0, 3'd7, 7'd3, 9'd4, 1'b0);
    @(negedge clk_i);
    checkOutput("illegal_done", int'(done_o), 2);
    checkOutput("illegal_err", int'(err_o), 1);
    checkOutput("illegal_en", int'(pim_en_o), 0);

    // PROGRAM aborted at index 3.
    applyStimulus(2'b01, 3'd2, 7'd9, 9'd100, 3'd0, 7'd0, 9'd0, 1'b0);
    applyStimulus(2'b00, 3'd2, 7'd9, 9'd100, 3'd0, 7'd0, 9'd0, 1'b0);
    waitCnt(3, ok);
    abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort3_en", int'(pim_en_o), 0);
    checkOutput("abort3_done", int'(done_o), 1);
    checkOutput("abort3_err", int'(err_o), 1);

    // Abort on the final PROGRAM cycle is ignored.
    applyStimulus(2'b01, 3'd2, 7'd10, 9'd200, 3'd0, 7'd0, 9'd0, 1'b0);
    applyStimulus(2'b00, 3'd2, 7'd10, 9'd200, 3'd0, 7'd0, 9'd0, 1'b0);
    waitCnt(11, ok);
    abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort11_done", int'(done_o), 1);
    checkOutput("abort11_err", int'(err_o), 0);

    // Both requesters hammering COMPUTE: requester 1 is favoured first.
    n_gr = 0;
    applyStimulus(2'b11, 3'd4, 7'd1, 9'd2, 3'd4, 7'd3, 9'd4, 1'b0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (req_ready_o != 2'b00 && n_gr < 8) begin
        grants[n_gr] = req_ready_o;
        n_gr++;
      end
    end
    applyStimulus(2'b00, 3'd0, 7'd0, 9'd0, 3'd0, 7'd0, 9'd0, 1'b0);
    checkOutput("rr_grant_count", n_gr, 5);
    for (int k = 0; k < 5 && k < n_gr; k++)
      checkOutput("rr_grant_order", int'(grants[k]), (k % 2 == 0) ? 2 : 1);

    // Reset mid-ERASE, then a tie must go to requester 0.
    applyStimulus(2'b10, 3'd0, 7'd0, 9'd0, 3'd3, 7'd77, 9'd300, 1'b0);
    applyStimulus(2'b00, 3'd0, 7'd0, 9'd0, 3'd3, 7'd77, 9'd300, 1'b0);
    waitCnt(6, ok);
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_en", int'(pim_en_o), 0);
    checkOutput("async_rst_busy", int'(busy_o), 0);
    checkOutput("async_rst_row", int'(row_addr7_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    applyStimulus(2'b11, 3'd1, 7'd1, 9'd1, 3'd1, 7'd2, 9'd2, 1'b0);
    @(negedge clk_i);
    checkOutput("post_rst_tie", int'(req_ready_o), 1);
    applyStimulus(2'b00, 3'd0, 7'd0, 9'd0, 3'd0, 7'd0, 9'd0, 1'b0);
    repeat (12) @(posedge clk_i);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk_i);
      #1;
      req_valid_i = 2'($urandom_range(0, 3));
      req0_mode_i = 3'($urandom_range(0, 7));
      req1_mode_i = 3'($urandom_range(0, 7));
      req0_row_i  = 7'($urandom);
      req1_row_i  = 7'($urandom);
      req0_col_i  = 9'($urandom);
      req1_col_i  = 9'($urandom);
      abort_i     = ($urandom_range(0, 11) == 0);
    end
    applyStimulus(2'b00, 3'd0, 7'd0, 9'd0, 3'd0, 7'd0, 9'd0, 1'b0);
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("drain_idle", int'(busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
